// File: rtl/dp_pkg.sv
// Shared definitions for the multi-cycle data path: opcode/func encodings,
// instruction field positions (as offsets from the MSB) and FSM states.
// Optional feature macro: PIPE_DATA_PATH_MUL_EN (enables ALU func 10, MUL).
package dp_pkg;

    // Field layout, measured from the instruction MSB so it scales with WIDTH
    localparam int OP_W        = 6;
    localparam int REG_FLD_W   = 5;
    localparam int OP_MSB_OFS  = 1;
    localparam int RD_MSB_OFS  = 7;
    localparam int RA_MSB_OFS  = 12;
    localparam int RB_MSB_OFS  = 17;
    localparam int IMM_MSB_OFS = 17;

    // Opcode classes in op[5:4]
    localparam logic [1:0] CLS_RR = 2'b00;
    localparam logic [1:0] CLS_RI = 2'b01;

    // Full opcodes
    localparam logic [5:0] OP_LOAD  = 6'b100000;
    localparam logic [5:0] OP_STORE = 6'b100001;
    localparam logic [5:0] OP_BEQ   = 6'b110000;
    localparam logic [5:0] OP_BNE   = 6'b110001;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // ALU functions
    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SUB  = 4'd1;
    localparam logic [3:0] FN_AND  = 4'd2;
    localparam logic [3:0] FN_OR   = 4'd3;
    localparam logic [3:0] FN_XOR  = 4'd4;
    localparam logic [3:0] FN_SLL  = 4'd5;
    localparam logic [3:0] FN_SRL  = 4'd6;
    localparam logic [3:0] FN_SRA  = 4'd7;
    localparam logic [3:0] FN_SLT  = 4'd8;
    localparam logic [3:0] FN_SLTU = 4'd9;
    localparam logic [3:0] FN_MUL  = 4'd10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    // MUL only exists when the multiplier is built in
    function automatic logic func_legal(input logic [3:0] f);
`ifdef PIPE_DATA_PATH_MUL_EN
        return (f <= FN_MUL);
`else
        return (f <= FN_SLTU);
`endif
    endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU for pipe_data_path. All arithmetic wraps modulo 2^WIDTH.
// Optional feature macro: PIPE_DATA_PATH_MUL_EN (adds the func 10 multiplier).
module dp_alu
    import dp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;

    assign shamt = b[SHW-1:0];

    // Function select; illegal funcs never reach here, they yield zero
    always_comb begin
        y = '0;
        case (func)
            FN_ADD:  y = a + b;
            FN_SUB:  y = a - b;
            FN_AND:  y = a & b;
            FN_OR:   y = a | b;
            FN_XOR:  y = a ^ b;
            FN_SLL:  y = a << shamt;
            FN_SRL:  y = a >> shamt;
            FN_SRA:  y = $signed(a) >>> shamt;
            FN_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            FN_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef PIPE_DATA_PATH_MUL_EN
            FN_MUL:  y = a * b;
`endif
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/pipe_data_path.sv
// Multi-cycle (FETCH/DECODE/EXEC/MEM/WB) data path with a single shared
// memory port and an inline register file; register 0 is hard-wired to zero.
// Optional feature macro: PIPE_DATA_PATH_MUL_EN (single-cycle MUL in EXEC).
module pipe_data_path
    import dp_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 8,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack,
    output logic [AWIDTH-1:0] pc,
    output logic              halted
);

    localparam int RIW    = $clog2(NREGS);
    localparam int OP_LSB = WIDTH - OP_MSB_OFS - OP_W + 1;
    localparam int RD_LSB = WIDTH - RD_MSB_OFS - REG_FLD_W + 1;
    localparam int RA_LSB = WIDTH - RA_MSB_OFS - REG_FLD_W + 1;
    localparam int RB_LSB = WIDTH - RB_MSB_OFS - REG_FLD_W + 1;
    localparam int IMM_W  = WIDTH - IMM_MSB_OFS + 1;

    state_e state, state_nxt;

    logic [WIDTH-1:0]  ir;
    logic [WIDTH-1:0]  rf [NREGS];
    logic [WIDTH-1:0]  opa, opb, res;
    logic [AWIDTH-1:0] npc;

    logic [5:0]             op;
    logic [3:0]             func;
    logic [RIW-1:0]         rd_idx, ra_idx, rb_idx, bsel_idx;
    logic signed [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0]       alu_b, alu_y;
    logic [AWIDTH-1:0]      mem_ea;
    logic legal, is_alu, is_ri, is_load, is_store, is_beq, is_bne, br_taken;

    logic              req_nxt, we_nxt, halt_nxt;
    logic [AWIDTH-1:0] addr_nxt, pc_nxt;
    logic [WIDTH-1:0]  wdata_nxt;
    logic              ld_ir, ld_ab, ld_exec, ld_load, rf_we;

    assign op       = ir[OP_LSB +: OP_W];
    assign func     = op[3:0];
    assign rd_idx   = ir[RD_LSB +: RIW];
    assign ra_idx   = ir[RA_LSB +: RIW];
    assign rb_idx   = ir[RB_LSB +: RIW];
    assign imm_ext  = {{(WIDTH-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

    assign is_alu   = ~op[5];
    assign is_ri    = (op[5:4] == CLS_RI);
    assign is_load  = (op == OP_LOAD);
    assign is_store = (op == OP_STORE);
    assign is_beq   = (op == OP_BEQ);
    assign is_bne   = (op == OP_BNE);

    // Stores and branches need rd as their second operand, so the B port
    // reads rd instead of rb for every non-ALU opcode.
    assign bsel_idx = op[5] ? rd_idx : rb_idx;
    assign alu_b    = is_ri ? imm_ext : opb;
    assign mem_ea   = opa[AWIDTH-1:0] + imm_ext[AWIDTH-1:0];
    assign br_taken = (is_beq && (opa == opb)) || (is_bne && (opa != opb));

    dp_alu #(.WIDTH(WIDTH)) u_alu (
        .func (func),
        .a    (opa),
        .b    (alu_b),
        .y    (alu_y)
    );

    // Opcode legality: ALU classes depend on func, the rest are listed opcodes
    always_comb begin
        unique case (op[5:4])
            CLS_RR, CLS_RI: legal = func_legal(func);
            default:        legal = is_load || is_store || is_beq || is_bne;
        endcase
    end

    // Next-state and registered-output values; mem_* only change on entry
    // to FETCH/MEM or on the accepting ack, so they stay stable while waiting
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        req_nxt   = 1'b0;
        we_nxt    = 1'b0;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        halt_nxt  = halted;
        ld_ir     = 1'b0;
        ld_ab     = 1'b0;
        ld_exec   = 1'b0;
        ld_load   = 1'b0;
        rf_we     = 1'b0;
        unique case (state)
            S_FETCH: begin
                if (mem_req && mem_ack) begin
                    ld_ir     = 1'b1;
                    state_nxt = S_DECODE;
                end else begin
                    req_nxt  = 1'b1;
                    addr_nxt = pc;
                end
            end
            S_DECODE: begin
                if (!legal || op == OP_HALT) begin
                    halt_nxt  = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    ld_ab     = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                ld_exec = 1'b1;
                if (is_load || is_store) begin
                    req_nxt   = 1'b1;
                    we_nxt    = is_store;
                    addr_nxt  = mem_ea;
                    wdata_nxt = opb;
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (mem_req && mem_ack) begin
                    ld_load   = is_load;
                    state_nxt = S_WB;
                end else begin
                    req_nxt = 1'b1;
                    we_nxt  = mem_we;
                end
            end
            S_WB: begin
                rf_we     = (is_alu || is_load) && (rd_idx != '0);
                pc_nxt    = npc;
                req_nxt   = 1'b1;
                addr_nxt  = npc;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halt_nxt = 1'b1;
            end
            default: begin
                halt_nxt  = 1'b1;
                state_nxt = S_HALT;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // Program counter, instruction register and memory-port outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= '0;
            ir        <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
        end else begin
            pc        <= pc_nxt;
            mem_req   <= req_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            halted    <= halt_nxt;
            if (ld_ir) ir <= mem_rdata;
        end
    end

    // Register file write port; entry 0 is never written so it reads as zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (rf_we) begin
            rf[rd_idx] <= res;
        end
    end

    // Operand latches, result and next-pc latches (pure data, no reset)
    always_ff @(posedge clk) begin
        if (ld_ab) begin
            opa <= rf[ra_idx];
            opb <= rf[bsel_idx];
        end
        if (ld_exec) begin
            res <= alu_y;
            npc <= br_taken ? (pc + imm_ext[AWIDTH-1:0]) : (pc + AWIDTH'(1));
        end
        if (ld_load) res <= mem_rdata;
    end

endmodule

// File: tb/tb_pipe_data_path.sv
// Self-checking bench for pipe_data_path: directed programs plus random
// programs compared against an instruction-level reference interpreter.
module tb_pipe_data_path;

    localparam logic [5:0] T_ADDI  = 6'b010000;
    localparam logic [5:0] T_SLLI  = 6'b010101;
    localparam logic [5:0] T_MUL   = 6'b001010;
    localparam logic [5:0] T_LOAD  = 6'b100000;
    localparam logic [5:0] T_STORE = 6'b100001;
    localparam logic [5:0] T_BEQ   = 6'b110000;
    localparam logic [5:0] T_BNE   = 6'b110001;
    localparam logic [5:0] T_HALT  = 6'b111111;

    logic        clk, reset;
    logic        mem_req, mem_we, mem_ack;
    logic [7:0]  mem_addr, pc;
    logic [31:0] mem_wdata, mem_rdata;
    logic        halted;

    pipe_data_path #(.WIDTH(32), .AWIDTH(8), .NREGS(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc        (pc),
        .halted    (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] mem [256];
    int          fixed_delay = 0;
    bit          noise = 0;
    int          cnt = 0, cur_delay = 0, cur_cycles = 0;
    bit          cur_stable;
    logic [7:0]  cur_addr;
    logic [31:0] cur_wd;
    logic        cur_we;
    int          wr_count = 0, last_wr_cycles = 0;
    bit          last_wr_stable = 0;
    logic [7:0]  reads_q [$];

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (!reset) begin
                cnt = 0;
            end else if (mem_req) begin
                if (cnt == 0) begin
                    cur_cycles = 0;
                    cur_stable = 1'b1;
                    cur_addr   = mem_addr;
                    cur_we     = mem_we;
                    cur_wd     = mem_wdata;
                    cur_delay  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                end else if (mem_addr !== cur_addr || mem_we !== cur_we ||
                             (cur_we && mem_wdata !== cur_wd)) begin
                    cur_stable = 1'b0;
                end
                cur_cycles++;
                if (cnt >= cur_delay) begin
                    mem_ack = 1'b1;
                    cnt = 0;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        wr_count++;
                        last_wr_cycles = cur_cycles;
                        last_wr_stable = cur_stable;
                    end else begin
                        mem_rdata = mem[mem_addr];
                        reads_q.push_back(mem_addr);
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
                if (noise) begin
                    mem_ack   = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] encr(input logic [5:0] op, input int rd, input int ra, input int rb);
        return {op, rd[4:0], ra[4:0], rb[4:0], 11'd0};
    endfunction

    function automatic logic [31:0] enci(input logic [5:0] op, input int rd, input int ra, input int imm);
        return {op, rd[4:0], ra[4:0], imm[15:0]};
    endfunction

    task automatic load_begin();
        @(negedge clk);
        reset = 1'b0;
        fixed_delay = 0;
        noise = 0;
        for (int a = 0; a < 256; a++) mem[a] = '0;
        reads_q.delete();
        wr_count = 0;
    endtask

    task automatic go();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    endtask

    // ---------------- reference interpreter ----------------
    logic [31:0] mmem [256];
    logic [31:0] mreg [32];
    logic [7:0]  mpc;

    function automatic logic [31:0] alu_ref(input int f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return a << b[4:0];
            6:  return a >> b[4:0];
            7:  return $signed(a) >>> b[4:0];
            8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            9:  return (a < b) ? 32'd1 : 32'd0;
            default: return a * b;
        endcase
    endfunction

    task automatic run_model();
        logic [31:0] ins, bv, val;
        logic [5:0]  op;
        int          rd, ra, rb, maxf;
        logic [31:0] imm;
        logic [7:0]  ad;
        bit          done;
`ifdef PIPE_DATA_PATH_MUL_EN
        maxf = 10;
`else
        maxf = 9;
`endif
        mpc = 0;
        done = 0;
        for (int r = 0; r < 32; r++) mreg[r] = '0;
        for (int step = 0; step < 5000 && !done; step++) begin
            ins = mmem[mpc];
            op  = ins[31:26];
            rd  = int'(ins[25:21]);
            ra  = int'(ins[20:16]);
            rb  = int'(ins[15:11]);
            imm = {{16{ins[15]}}, ins[15:0]};
            ad  = 8'(mreg[ra] + imm);
            if (op[5:4] == 2'b00 || op[5:4] == 2'b01) begin
                if (int'(op[3:0]) > maxf) begin
                    done = 1;
                end else begin
                    bv  = op[4] ? imm : mreg[rb];
                    val = alu_ref(int'(op[3:0]), mreg[ra], bv);
                    if (rd != 0) mreg[rd] = val;
                    mpc = mpc + 8'd1;
                end
            end else if (op == T_LOAD) begin
                if (rd != 0) mreg[rd] = mmem[ad];
                mpc = mpc + 8'd1;
            end else if (op == T_STORE) begin
                mmem[ad] = mreg[rd];
                mpc = mpc + 8'd1;
            end else if (op == T_BEQ || op == T_BNE) begin
                if ((mreg[rd] == mreg[ra]) == (op == T_BEQ)) mpc = mpc + imm[7:0];
                else mpc = mpc + 8'd1;
            end else begin
                done = 1;
            end
        end
    endtask

    task automatic gen_prog();
        int n, k, maxf;
`ifdef PIPE_DATA_PATH_MUL_EN
        maxf = 10;
`else
        maxf = 9;
`endif
        n = 0;
        for (int a = 8'hC0; a < 256; a++) mem[a] = $urandom;
        for (int i = 0; i < 10; i++) mem[n++] = enci(T_ADDI, $urandom_range(1, 31), 0, $urandom);
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 9);
            if (k <= 2)
                mem[n++] = encr({2'b00, 4'($urandom_range(0, maxf))}, $urandom_range(0, 31),
                                $urandom_range(0, 31), $urandom_range(0, 31));
            else if (k <= 5)
                mem[n++] = enci({2'b01, 4'($urandom_range(0, maxf))}, $urandom_range(0, 31),
                                $urandom_range(0, 31), $urandom);
            else if (k == 6)
                mem[n++] = enci(T_LOAD, $urandom_range(0, 31), 0, 8'hC0 + $urandom_range(0, 63));
            else if (k == 7)
                mem[n++] = enci(T_STORE, $urandom_range(0, 31), 0, 8'hC0 + $urandom_range(0, 63));
            else if (k == 8)
                mem[n++] = enci($urandom_range(0, 1) ? T_BEQ : T_BNE, $urandom_range(0, 31),
                                $urandom_range(0, 31), $urandom_range(1, 3));
            else
                mem[n++] = enci(T_ADDI, $urandom_range(1, 31), $urandom_range(0, 31), $urandom);
        end
        for (int r = 1; r < 32; r++) mem[n++] = enci(T_STORE, r, 0, 8'h80 + r);
        mem[n] = enci(T_HALT, 0, 0, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int viol;
        reset = 1'b0;
        #12;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);

        // ADDI chain with immediate acks: one instruction per 4 cycles
        load_begin();
        mem[0] = enci(T_ADDI, 1, 0, 5);
        mem[1] = enci(T_ADDI, 2, 1, -7);
        mem[2] = enci(T_STORE, 2, 0, 8'h40);
        mem[3] = enci(T_HALT, 0, 0, 0);
        go();
        repeat (5) @(posedge clk);
        #1 chk("addi_pc_after5", pc, 1);
        repeat (5) @(posedge clk);
        #1 chk("addi_pc_after10", pc, 2);
        wait_halt(100);
        chk("addi_halted", halted, 1);
        chk("addi_r2", mem[8'h40], 32'hFFFF_FFFE);
        chk("addi_pc_final", pc, 3);

        // Store with a 4-cycle ack delay: request held stable for 5 cycles
        load_begin();
        fixed_delay = 4;
        mem[0] = enci(T_ADDI, 2, 0, 16'h1234);
        mem[1] = enci(T_ADDI, 1, 0, 16'h10);
        mem[2] = enci(T_STORE, 2, 1, 3);
        mem[3] = enci(T_HALT, 0, 0, 0);
        go();
        wait_halt(300);
        chk("st_halted", halted, 1);
        chk("st_writes", wr_count, 1);
        chk("st_req_cycles", last_wr_cycles, 5);
        chk("st_stable", last_wr_stable, 1);
        chk("st_data", mem[8'h13], 32'h1234);

        // BEQ r0,r0,-1 at pc=5 loops back to 4
        load_begin();
        for (int i = 0; i < 5; i++) mem[i] = enci(T_ADDI, 0, 0, 0);
        mem[5] = enci(T_BEQ, 0, 0, -1);
        go();
        for (int i = 0; i < 200 && reads_q.size() < 8; i++) @(negedge clk);
        chk("beq_nfetch", (reads_q.size() >= 8), 1);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] expv, gotv;
            expv = (i < 6) ? 8'(i) : 8'(i - 2);
            gotv = (i < reads_q.size()) ? reads_q[i] : 8'hFF;
            chk($sformatf("beq_fetch%0d", i), gotv, expv);
        end

        // BNE r0,r0,-1 falls through to 6
        load_begin();
        for (int i = 0; i < 5; i++) mem[i] = enci(T_ADDI, 0, 0, 0);
        mem[5] = enci(T_BNE, 0, 0, -1);
        mem[6] = enci(T_HALT, 0, 0, 0);
        go();
        wait_halt(200);
        chk("bne_halted", halted, 1);
        chk("bne_pc", pc, 6);

        // Illegal opcode: halt, pc frozen, no requests even with stray acks
        load_begin();
        mem[0] = {6'b101010, 26'd0};
        go();
        noise = 1;
        wait_halt(50);
        chk("ill_halted", halted, 1);
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || pc !== 8'd0 || halted !== 1'b1) viol++;
        end
        chk("ill_quiet", viol, 0);
        noise = 0;

        // Reset in the middle of a long LOAD wait
        load_begin();
        mem[0] = enci(T_LOAD, 1, 0, 8'hC0);
        go();
        for (int i = 0; i < 20 && reads_q.size() < 1; i++) @(negedge clk);
        fixed_delay = 50;
        for (int i = 0; i < 20 && !(mem_req && mem_addr == 8'hC0); i++) @(negedge clk);
        chk("rld_waiting", (mem_req && mem_addr == 8'hC0), 1);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("rld_req_drop", mem_req, 0);
        chk("rld_addr_clr", mem_addr, 0);
        fixed_delay = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
        chk("rld_first_req", mem_req, 1);
        chk("rld_first_addr", mem_addr, 0);
        chk("rld_first_we", mem_we, 0);

        // MUL 0x10000*0x10000
        load_begin();
        mem[0] = enci(T_ADDI, 1, 0, 1);
        mem[1] = enci(T_SLLI, 1, 1, 16);
        mem[2] = encr(T_MUL, 3, 1, 1);
        mem[3] = enci(T_STORE, 3, 0, 8'h90);
        mem[4] = enci(T_HALT, 0, 0, 0);
        mem[8'h90] = 32'hDEAD_BEEF;
        go();
        wait_halt(200);
        chk("mul_halted", halted, 1);
`ifdef PIPE_DATA_PATH_MUL_EN
        chk("mul_pc", pc, 4);
        chk("mul_r3", mem[8'h90], 32'h0);
`else
        chk("mul_pc", pc, 2);
        chk("mul_r3", mem[8'h90], 32'hDEAD_BEEF);
`endif

        // Random programs with random ack delays and stray acks
        for (int s = 0; s < 3; s++) begin
            load_begin();
            gen_prog();
            for (int a = 0; a < 256; a++) mmem[a] = mem[a];
            run_model();
            fixed_delay = -1;
            noise = 1;
            go();
            wait_halt(8000);
            noise = 0;
            chk($sformatf("rnd%0d_halted", s), halted, 1);
            chk($sformatf("rnd%0d_pc", s), pc, mpc);
            for (int a = 8'h80; a < 256; a++)
                chk($sformatf("rnd%0d_mem%0h", s, a), mem[a], mmem[a]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
